// File: rtl/letter_scroller.sv
// letter_scroller: buffers a message of 5-bit letter codes and scrolls it right-to-left across DIGITS multiplexed displays.
// Optional macro SCROLL_LOOP_EN: the scroll wraps to position 0 forever instead of ending a pass with a done pulse.
module letter_scroller #(
    parameter int MSG_DEPTH   = 16,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int STEP_DIV    = 50000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    input  logic [4:0]        wr_code,
    input  logic              wr_last,
    output logic              wr_ready,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [4:0]        code_out,
    output logic [DIGITS-1:0] an_n
);
    localparam int CW = $clog2(MSG_DEPTH + 1);
    localparam int AW = $clog2(MSG_DEPTH);
    localparam int PW = $clog2(MSG_DEPTH + DIGITS + 1);
    localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DW = $clog2(DIGITS);

    typedef enum logic [1:0] {EMPTY, LOADING, READY, SCROLL} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [CW-1:0] len;
    logic [PW-1:0] pos;
    logic [SW-1:0] step_cnt;
    logic [RW-1:0] ref_cnt;
    logic [DW-1:0] digit;
    logic [4:0]    mem [MSG_DEPTH];

    logic          wr_fire;
    logic [AW-1:0] wr_idx;
    logic [4:0]    wr_clean;
    logic [CW-1:0] count_inc;
    logic [PW-1:0] pos_inc;
    logic [PW-1:0] pos_end;
    logic [4:0]    win_code;
    int            widx;

    // Only glyph codes 1..18 survive; everything else, including the decoder's hold code, becomes blank.
    function automatic logic [4:0] clean_code(input logic [4:0] c);
        return (c >= 5'd1 && c <= 5'd18) ? c : 5'd0;
    endfunction

    always_comb begin
        wr_fire   = wr_valid && wr_ready;
        wr_idx    = (state == LOADING) ? count[AW-1:0] : '0;
        wr_clean  = clean_code(wr_code);
        count_inc = count + CW'(1);
        pos_inc   = pos + PW'(1);
        pos_end   = PW'(len) + PW'(DIGITS);
    end

    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[wr_idx] <= wr_clean;
    end

    // Letter shown by the active digit; positions left of the message or past its end are blank.
    always_comb begin
        widx     = int'(pos) + int'(digit) - (DIGITS - 1);
        win_code = 5'd0;
        if (widx >= 0 && widx < int'(len))
            win_code = mem[widx[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            count    <= '0;
            len      <= '0;
            pos      <= '0;
            step_cnt <= '0;
            wr_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                EMPTY, READY: begin
                    if (wr_fire) begin
                        count <= CW'(1);
                        if (wr_last) begin
                            len   <= CW'(1);
                            state <= READY;
                        end else begin
                            state <= LOADING;
                        end
                    end else if (state == READY && start) begin
                        pos      <= '0;
                        step_cnt <= '0;
                        state    <= SCROLL;
                        busy     <= 1'b1;
                        wr_ready <= 1'b0;
                    end
                end
                LOADING: begin
                    if (count == CW'(MSG_DEPTH)) begin
                        len      <= count;
                        state    <= READY;
                        wr_ready <= 1'b1;
                    end else if (wr_fire) begin
                        count <= count_inc;
                        if (wr_last) begin
                            len   <= count_inc;
                            state <= READY;
                        end else begin
                            wr_ready <= (count_inc < CW'(MSG_DEPTH));
                        end
                    end
                end
                SCROLL: begin
                    if (abort) begin
                        state    <= READY;
                        busy     <= 1'b0;
                        wr_ready <= 1'b1;
                    end else if (step_cnt == SW'(STEP_DIV - 1)) begin
                        step_cnt <= '0;
                        if (pos_inc == pos_end) begin
`ifdef SCROLL_LOOP_EN
                            pos <= '0;
`else
                            state    <= READY;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            wr_ready <= 1'b1;
`endif
                        end else begin
                            pos <= pos_inc;
                        end
                    end else begin
                        step_cnt <= step_cnt + SW'(1);
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // The refresh walk runs in every state so the digit phase never depends on when scrolling began.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt  <= '0;
            digit    <= '0;
            an_n     <= '1;
            code_out <= 5'd0;
        end else begin
            if (ref_cnt == RW'(REFRESH_DIV - 1)) begin
                ref_cnt <= '0;
                digit   <= (digit == DW'(DIGITS - 1)) ? '0 : digit + DW'(1);
            end else begin
                ref_cnt <= ref_cnt + RW'(1);
            end
            if (state == SCROLL) begin
                an_n     <= ~(DIGITS'(1) << digit);
                code_out <= win_code;
            end else begin
                an_n     <= '1;
                code_out <= 5'd0;
            end
        end
    end
endmodule

// File: tb/tb_letter_scroller.sv
// tb_letter_scroller: randomized and directed stimulus against a queue-based message model of letter_scroller.
// Builds correctly with or without SCROLL_LOOP_EN defined.
module tb_letter_scroller;
    localparam int MSG_DEPTH   = 16;
    localparam int DIGITS      = 4;
    localparam int REFRESH_DIV = 2;
    localparam int STEP_DIV    = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_valid = 1'b0;
    logic [4:0]        wr_code = 5'd0;
    logic              wr_last = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              wr_ready;
    logic              busy;
    logic              done;
    logic [4:0]        code_out;
    logic [DIGITS-1:0] an_n;

    int tests = 0;
    int fails = 0;
    int seen20 = 0;
    int seen18 = 0;

    logic [4:0] pos2_exp [DIGITS] = '{5'd0, 5'd3, 5'd1, 5'd2};

    letter_scroller #(
        .MSG_DEPTH(MSG_DEPTH),
        .DIGITS(DIGITS),
        .REFRESH_DIV(REFRESH_DIV),
        .STEP_DIV(STEP_DIV)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_valid(wr_valid),
        .wr_code(wr_code),
        .wr_last(wr_last),
        .wr_ready(wr_ready),
        .start(start),
        .abort(abort),
        .busy(busy),
        .done(done),
        .code_out(code_out),
        .an_n(an_n)
    );

    always #5 clk = ~clk;

    // Model: the committed message and the one being typed are plain queues; the display is derived from elapsed cycles.
    logic [4:0]        msg[$];
    logic [4:0]        build[$];
    bit                building = 0;
    bit                has_msg = 0;
    bit                scrolling = 0;
    int                pos = 0;
    int                step_cycles = 0;
    int                ncyc = 0;
    int                mdigit = 0;
    bit                acc = 0;
    logic              exp_done = 1'b0;
    logic [4:0]        exp_code = 5'd0;
    logic [DIGITS-1:0] exp_an = '1;
    logic [31:0]       act_vec;
    logic [31:0]       req_vec;

    function automatic logic [4:0] legal(input logic [4:0] c);
        return (c >= 5'd1 && c <= 5'd18) ? c : 5'd0;
    endfunction

    function automatic bit model_ready();
        return !scrolling && !(building && build.size() == MSG_DEPTH);
    endfunction

    function automatic logic [4:0] window_code(input int p, input int k);
        int i;
        i = p - (DIGITS - 1) + k;
        if (i < 0 || i >= msg.size())
            return 5'd0;
        return msg[i];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg.delete();
            build.delete();
            building    = 0;
            has_msg     = 0;
            scrolling   = 0;
            pos         = 0;
            step_cycles = 0;
            ncyc        = 0;
            exp_done    = 1'b0;
            exp_code    = 5'd0;
            exp_an      = '1;
        end else begin
            mdigit   = (ncyc / REFRESH_DIV) % DIGITS;
            exp_an   = '1;
            exp_code = 5'd0;
            if (scrolling) begin
                exp_an[mdigit] = 1'b0;
                exp_code       = window_code(pos, mdigit);
            end
            exp_done = 1'b0;
            acc      = wr_valid && model_ready();
            if (scrolling) begin
                if (abort) begin
                    scrolling = 0;
                end else begin
                    step_cycles++;
                    if (step_cycles == STEP_DIV) begin
                        step_cycles = 0;
                        pos++;
                        if (pos == msg.size() + DIGITS) begin
`ifdef SCROLL_LOOP_EN
                            pos = 0;
`else
                            scrolling = 0;
                            exp_done  = 1'b1;
`endif
                        end
                    end
                end
            end else if (acc) begin
                if (!building)
                    build.delete();
                build.push_back(legal(wr_code));
                if (wr_last) begin
                    msg      = build;
                    has_msg  = 1;
                    building = 0;
                end else begin
                    building = 1;
                end
            end else if (building && build.size() == MSG_DEPTH) begin
                msg      = build;
                has_msg  = 1;
                building = 0;
            end else if (start && has_msg && !building) begin
                scrolling   = 1;
                pos         = 0;
                step_cycles = 0;
            end
            ncyc++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        tests++;
        if (actual !== required) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, required, $time);
        end
    endtask

    // Every cycle, the registered outputs must match what the model predicts.
    always @(negedge clk) begin
        act_vec = {20'd0, wr_ready, busy, done, code_out, an_n};
        req_vec = {20'd0, model_ready(), scrolling, exp_done, exp_code, exp_an};
        checkOutput("cycle_outputs", act_vec, req_vec);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (code_out == 5'd20) seen20++;
            if (code_out == 5'd18) seen18++;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic v, input logic [4:0] c, input logic l, input logic s, input logic a);
        wr_valid = v;
        wr_code  = c;
        wr_last  = l;
        start    = s;
        abort    = a;
        @(negedge clk);
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
    endtask

    // Called right after a start: the next eight outputs show position 0, only the rightmost digit lit with msg[0].
    task automatic checkPos0(input logic [4:0] first);
        int right;
        right = 0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (an_n == 4'b0111) begin
                right++;
                checkOutput("pos0_right", code_out, first);
            end else begin
                checkOutput("pos0_blank", code_out, 5'd0);
            end
        end
        checkOutput("pos0_right_slots", right, 2);
    endtask

    task automatic waitPass(input int limit, output int n);
        n = 0;
`ifdef SCROLL_LOOP_EN
        repeat (limit) @(negedge clk);
        n = limit;
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
`else
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
`endif
        checkOutput("pass_end_busy", busy, 1'b0);
    endtask

    initial begin
        int n;
        int dcount;
        int hits;
        logic v, l, s, a;

        repeat (2) @(negedge clk);
        checkOutput("reset_an_n", an_n, 4'b1111);
        checkOutput("reset_code_out", code_out, 5'd0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_wr_ready", wr_ready, 1'b1);
        checkOutput("reset_done", done, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // C, A, B then start
        applyStimulus(1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("busy_after_start", busy, 1'b1);
        checkPos0(5'd3);
        repeat (8) @(negedge clk);
        hits = 0;
        for (int j = 17; j <= 24; j++) begin
            @(negedge clk);
            for (int k = 0; k < DIGITS; k++) begin
                if (an_n == ~(4'b0001 << k)) begin
                    hits++;
                    checkOutput("pos2_digit", code_out, pos2_exp[k]);
                end
            end
        end
        checkOutput("pos2_slots", hits, 8);
`ifndef SCROLL_LOOP_EN
        dcount = 0;
        for (int j = 25; j <= 60; j++) begin
            @(negedge clk);
            if (done) begin
                dcount++;
                checkOutput("done_cycle", j, 56);
            end
        end
        checkOutput("done_count", dcount, 1);
        checkOutput("busy_after_done", busy, 1'b0);
`else
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
`endif

        // Illegal codes become blank
        applyStimulus(1'b1, 5'd20, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd25, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd18, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        checkPos0(5'd0);
        waitPass(200, n);
        checkOutput("seen_18", seen18 > 0, 1'b1);
        repeat (2) @(negedge clk);

        // Fill to capacity with no last marker
        for (int i = 0; i < MSG_DEPTH; i++)
            applyStimulus(1'b1, 5'(i + 1), 1'b0, 1'b0, 1'b0);
        checkOutput("full_wr_ready", wr_ready, 1'b0);
        applyStimulus(1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        checkOutput("ready_after_full", wr_ready, 1'b1);
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        waitPass(400, n);
`ifndef SCROLL_LOOP_EN
        checkOutput("full_pass_cycles", n, (MSG_DEPTH + DIGITS) * STEP_DIV);
`endif
        repeat (2) @(negedge clk);

        // Abort at position 3, then restart the same message
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        repeat (26) @(negedge clk);
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_done", done, 1'b0);
        repeat (4) @(negedge clk);
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        checkPos0(5'd1);
        waitPass(400, n);
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of a scroll
        applyStimulus(1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_an_n", an_n, 4'b1111);
        checkOutput("async_code_out", code_out, 5'd0);
        checkOutput("async_busy", busy, 1'b0);
        checkOutput("async_wr_ready", wr_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifdef SCROLL_LOOP_EN
        // Two-letter message wraps back to position 0 after position 5
        applyStimulus(1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        repeat (48) @(negedge clk);
        checkPos0(5'd5);
        dcount = 0;
        repeat (100) begin
            @(negedge clk);
            if (done) dcount++;
        end
        checkOutput("loop_done_count", dcount, 0);
        checkOutput("loop_busy", busy, 1'b1);
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("loop_abort_busy", busy, 1'b0);
`endif

        // Random traffic, including writes racing starts and stray aborts
        for (int it = 0; it < 2500; it++) begin
            v = ($urandom_range(0, 99) < 40);
            l = ($urandom_range(0, 99) < 20);
            s = ($urandom_range(0, 99) < 12);
            a = ($urandom_range(0, 99) < 2);
            applyStimulus(v, 5'($urandom_range(0, 31)), l, s, a);
        end

        checkOutput("never_20", seen20, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
